// File: rtl/ss_scan_decoder.sv
// Loopback monitor for a 4-digit multiplexed seven-segment bus: settles each anode slot,
// decodes its glyph and publishes a coherent frame. Hex glyphs A-F: define SS_SCAN_HEX_DIGITS_EN.
module ss_scan_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       Clk_100M,
  input  logic       Reset,
  input  logic [3:0] SegmentDrivers,
  input  logic [7:0] SevenSegment,
  output logic [3:0] Digit3,
  output logic [3:0] Digit2,
  output logic [3:0] Digit1,
  output logic [3:0] Digit0,
  output logic [3:0] Dp,
  output logic [3:0] Digit_Err,
  output logic       Frame_Done,
  output logic       Digit_Valid,
  output logic       Anode_Error
);

  localparam int NUM_DIGITS = 4;
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ST_W-1:0] ST_MAX = ST_W'(SETTLE_CYCLES);
  localparam logic [ST_W-1:0] ST_CAP = ST_W'(SETTLE_CYCLES - 2);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_ACQUIRE = 2'd0;
  localparam logic [1:0] S_PUBLISH = 2'd1;
  localparam logic [1:0] S_STALLED = 2'd2;

  // Returns {err, digit}; anything outside the table decodes as digit 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = {1'b0, 4'd0};
      7'h06:   decode = {1'b0, 4'd1};
      7'h5B:   decode = {1'b0, 4'd2};
      7'h4F:   decode = {1'b0, 4'd3};
      7'h66:   decode = {1'b0, 4'd4};
      7'h6D:   decode = {1'b0, 4'd5};
      7'h7D:   decode = {1'b0, 4'd6};
      7'h07:   decode = {1'b0, 4'd7};
      7'h7F:   decode = {1'b0, 4'd8};
      7'h6F:   decode = {1'b0, 4'd9};
`ifdef SS_SCAN_HEX_DIGITS_EN
      7'h77:   decode = {1'b0, 4'd10};
      7'h7C:   decode = {1'b0, 4'd11};
      7'h39:   decode = {1'b0, 4'd12};
      7'h5E:   decode = {1'b0, 4'd13};
      7'h79:   decode = {1'b0, 4'd14};
      7'h71:   decode = {1'b0, 4'd15};
`endif
      default: decode = {1'b1, 4'd0};
    endcase
  endfunction

  logic [3:0]            an_q, an_p_q;
  logic [7:0]            seg_q, seg_p_q;
  logic [ST_W-1:0]       cnt_q, cnt_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [1:0]            state_q, state_d;
  logic [3:0]            mask_q, mask_d;
  logic [NUM_DIGITS-1:0][3:0] sh_dig_q, dig_q;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_err_q, dp_q, err_q;
  logic                  fd_q, valid_q, aerr_q;

  logic [3:0] an_low, slot_oh;
  logic [6:0] pat;
  logic       dp_w, an_one, an_blank, an_multi, same, capture;
  logic [1:0] slot;
  logic [4:0] dec;

  // Input sample stage; the previous sample is kept for the stability compare.
  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      an_q    <= 4'hF;
      an_p_q  <= 4'hF;
      seg_q   <= 8'hFF;
      seg_p_q <= 8'hFF;
    end else begin
      an_q    <= SegmentDrivers;
      an_p_q  <= an_q;
      seg_q   <= SevenSegment;
      seg_p_q <= seg_q;
    end
  end

  always_comb begin
    an_low   = ~an_q;
    pat      = ~seg_q[6:0];
    dp_w     = ~seg_q[7];
    an_blank = (an_low == 4'b0000);
    an_one   = $onehot(an_low);
    an_multi = !an_blank && !an_one;
    same     = (an_q == an_p_q) && (seg_q == seg_p_q);
    dec      = decode(pat);
    case (an_low)
      4'b0001: slot = 2'd0;
      4'b0010: slot = 2'd1;
      4'b0100: slot = 2'd2;
      4'b1000: slot = 2'd3;
      default: slot = 2'd0;
    endcase
    slot_oh = 4'b0001 << slot;
  end

  // Capture fires on the one transition into SETTLE_CYCLES-1; saturation prevents a repeat.
  always_comb begin
    cnt_d = cnt_q;
    if (!an_one || !same)
      cnt_d = '0;
    else if (cnt_q != ST_MAX)
      cnt_d = cnt_q + ST_W'(1);
  end

  assign capture = an_one && same && (cnt_q == ST_CAP);

  // Frame assembly, publish and stall detection; a capture always beats a timeout.
  always_comb begin
    mask_d  = mask_q;
    state_d = state_q;
    to_d    = to_q;
    if (state_q == S_PUBLISH) begin
      mask_d  = 4'b0000;
      state_d = S_ACQUIRE;
    end
    if (capture) begin
      mask_d  = ((state_q == S_PUBLISH) ? 4'b0000 : mask_q) | slot_oh;
      to_d    = '0;
      state_d = (mask_d == 4'hF) ? S_PUBLISH : S_ACQUIRE;
    end else if (to_q != TO_MAX) begin
      to_d = to_q + TO_W'(1);
      if (to_d == TO_MAX) begin
        mask_d  = 4'b0000;
        state_d = S_STALLED;
      end
    end
  end

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      cnt_q   <= '0;
      to_q    <= '0;
      state_q <= S_ACQUIRE;
      mask_q  <= 4'b0000;
    end else begin
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_shadow
    always_ff @(posedge Clk_100M) begin
      if (Reset) begin
        sh_dig_q[i] <= 4'd0;
        sh_dp_q[i]  <= 1'b0;
        sh_err_q[i] <= 1'b0;
      end else if (capture && slot_oh[i]) begin
        sh_dig_q[i] <= dec[3:0];
        sh_dp_q[i]  <= dp_w;
        sh_err_q[i] <= dec[4];
      end
    end
  end

  // Publish loads outputs from the shadows; a stall only drops Digit_Valid.
  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      dig_q   <= '0;
      dp_q    <= '0;
      err_q   <= '0;
      fd_q    <= 1'b0;
      valid_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      fd_q   <= 1'b0;
      aerr_q <= aerr_q | an_multi;
      if (state_q == S_PUBLISH) begin
        dig_q   <= sh_dig_q;
        dp_q    <= sh_dp_q;
        err_q   <= sh_err_q;
        fd_q    <= 1'b1;
        valid_q <= 1'b1;
      end
      if (state_d == S_STALLED && state_q != S_STALLED)
        valid_q <= 1'b0;
    end
  end

  assign Digit3      = dig_q[3];
  assign Digit2      = dig_q[2];
  assign Digit1      = dig_q[1];
  assign Digit0      = dig_q[0];
  assign Dp          = dp_q;
  assign Digit_Err   = err_q;
  assign Frame_Done  = fd_q;
  assign Digit_Valid = valid_q;
  assign Anode_Error = aerr_q;

endmodule

// File: tb/tb_ss_scan_decoder.sv
// Directed bench for ss_scan_decoder: scans known glyphs and checks the decoded frames.
module tb_ss_scan_decoder;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 1000;

  localparam logic [6:0] G0 = 7'h3F, G1 = 7'h06, G2 = 7'h5B, G3 = 7'h4F, G4 = 7'h66;
  localparam logic [6:0] G5 = 7'h6D, G6 = 7'h7D, G7 = 7'h07, G8 = 7'h7F, G9 = 7'h6F;
  localparam logic [6:0] GB = 7'h7C;

  logic       Clk_100M = 1'b0;
  logic       Reset;
  logic [3:0] SegmentDrivers;
  logic [7:0] SevenSegment;
  logic [3:0] Digit3, Digit2, Digit1, Digit0, Dp, Digit_Err;
  logic       Frame_Done, Digit_Valid, Anode_Error;

  int n_chk  = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  int fd_base;
  int k;

  ss_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .Clk_100M(Clk_100M), .Reset(Reset),
    .SegmentDrivers(SegmentDrivers), .SevenSegment(SevenSegment),
    .Digit3(Digit3), .Digit2(Digit2), .Digit1(Digit1), .Digit0(Digit0),
    .Dp(Dp), .Digit_Err(Digit_Err), .Frame_Done(Frame_Done),
    .Digit_Valid(Digit_Valid), .Anode_Error(Anode_Error)
  );

  always #5 Clk_100M = ~Clk_100M;

  always @(posedge Clk_100M) if (Frame_Done === 1'b1) fd_cnt <= fd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] p, input logic dp, input int n);
    SegmentDrivers = an;
    SevenSegment   = ~{dp, p};
    repeat (n) @(negedge Clk_100M);
  endtask

  task automatic blank(input int n);
    hold(4'hF, 7'h00, 1'b0, n);
  endtask

  task automatic scan(input logic [6:0] p3, p2, p1, p0, input logic [3:0] dpm);
    hold(4'b0111, p3, dpm[3], 50);
    hold(4'b1011, p2, dpm[2], 50);
    hold(4'b1101, p1, dpm[1], 50);
    hold(4'b1110, p0, dpm[0], 50);
    blank(5);
  endtask

  // Each slot opens with a 5-cycle wrong glyph before the real one.
  task automatic gscan(input logic [6:0] p3, p2, p1, p0, input logic [3:0] dpm);
    hold(4'b0111, GB, 1'b0, 5); hold(4'b0111, p3, dpm[3], 40);
    hold(4'b1011, GB, 1'b0, 5); hold(4'b1011, p2, dpm[2], 40);
    hold(4'b1101, GB, 1'b0, 5); hold(4'b1101, p1, dpm[1], 40);
    hold(4'b1110, GB, 1'b0, 5); hold(4'b1110, p0, dpm[0], 40);
    blank(5);
  endtask

  task automatic chk_frame(input string tag, input logic [3:0] d3, d2, d1, d0, dp, err);
    chk({tag, "_d3"}, Digit3, d3);
    chk({tag, "_d2"}, Digit2, d2);
    chk({tag, "_d1"}, Digit1, d1);
    chk({tag, "_d0"}, Digit0, d0);
    chk({tag, "_dp"}, Dp, dp);
    chk({tag, "_err"}, Digit_Err, err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    SegmentDrivers = 4'hF;
    SevenSegment   = 8'hFF;
    repeat (5) @(negedge Clk_100M);
    chk_frame("rst", 4'd0, 4'd0, 4'd0, 4'd0, 4'h0, 4'h0);
    chk("rst_fd", Frame_Done, 0);
    chk("rst_valid", Digit_Valid, 0);
    chk("rst_aerr", Anode_Error, 0);
    Reset = 1'b0;
    blank(3);

    // 12:34, dp off
    fd_base = fd_cnt;
    scan(G1, G2, G3, G4, 4'b0000);
    chk("f1234_fd", fd_cnt - fd_base, 1);
    chk_frame("f1234", 4'd1, 4'd2, 4'd3, 4'd4, 4'h0, 4'h0);
    chk("f1234_valid", Digit_Valid, 1);

    // glitches before each slot; colon dp on digit 2
    fd_base = fd_cnt;
    gscan(G5, G6, G7, G8, 4'b0100);
    chk("glitch_fd", fd_cnt - fd_base, 1);
    chk_frame("glitch", 4'd5, 4'd6, 4'd7, 4'd8, 4'b0100, 4'h0);

    // 'b' glyph on digit 1
    fd_base = fd_cnt;
    scan(G1, G2, GB, G4, 4'b0000);
    chk("hexb_fd", fd_cnt - fd_base, 1);
`ifdef SS_SCAN_HEX_DIGITS_EN
    chk_frame("hexb", 4'd1, 4'd2, 4'd11, 4'd4, 4'h0, 4'h0);
`else
    chk_frame("hexb", 4'd1, 4'd2, 4'd0, 4'd4, 4'h0, 4'b0010);
`endif

    // two anodes low: sticky error, no capture
    fd_base = fd_cnt;
    hold(4'b0011, G8, 1'b0, 30);
    blank(5);
    chk("aerr_set", Anode_Error, 1);
    chk("aerr_nofd", fd_cnt - fd_base, 0);
    scan(G2, G0, G5, G9, 4'b0000);
    chk("aerr_fd", fd_cnt - fd_base, 1);
    chk_frame("aerr", 4'd2, 4'd0, 4'd5, 4'd9, 4'h0, 4'h0);
    chk("aerr_sticky", Anode_Error, 1);

    // stall: Frame_Done is one edge after the final capture, so 999 more edges to the fall
    fd_base = fd_cnt;
    hold(4'b0111, G1, 1'b0, 50);
    hold(4'b1011, G2, 1'b0, 50);
    hold(4'b1101, G3, 1'b0, 50);
    SegmentDrivers = 4'b1110;
    SevenSegment   = ~{1'b0, G4};
    k = 0;
    while (Frame_Done !== 1'b1 && k < 100) begin
      @(negedge Clk_100M);
      k++;
    end
    chk("to_fd_seen", Frame_Done, 1);
    chk("to_valid_pub", Digit_Valid, 1);
    SegmentDrivers = 4'hF;
    SevenSegment   = 8'hFF;
    @(negedge Clk_100M);
    chk("fd_pulse_width", Frame_Done, 0);
    k = 1;
    while (Digit_Valid === 1'b1 && k < 2000) begin
      @(negedge Clk_100M);
      k++;
    end
    chk("to_latency", k, 999);
    chk("to_valid", Digit_Valid, 0);
    blank(20);
    chk_frame("to_hold", 4'd1, 4'd2, 4'd3, 4'd4, 4'h0, 4'h0);
    chk("to_fd_once", fd_cnt - fd_base, 1);

    // resume after stall
    fd_base = fd_cnt;
    scan(G9, G0, G1, G2, 4'b0001);
    chk("resume_fd", fd_cnt - fd_base, 1);
    chk_frame("resume", 4'd9, 4'd0, 4'd1, 4'd2, 4'b0001, 4'h0);
    chk("resume_valid", Digit_Valid, 1);

    // reset after two captures discards the partial frame
    hold(4'b0111, G3, 1'b0, 50);
    hold(4'b1011, G7, 1'b0, 50);
    Reset = 1'b1;
    blank(2);
    chk_frame("mrst", 4'd0, 4'd0, 4'd0, 4'd0, 4'h0, 4'h0);
    chk("mrst_valid", Digit_Valid, 0);
    chk("mrst_aerr", Anode_Error, 0);
    Reset = 1'b0;
    blank(3);
    fd_base = fd_cnt;
    hold(4'b1101, G5, 1'b0, 50);
    hold(4'b1110, G6, 1'b0, 50);
    blank(5);
    chk("mrst_half_nofd", fd_cnt - fd_base, 0);
    hold(4'b0111, G3, 1'b0, 50);
    hold(4'b1011, G7, 1'b0, 50);
    blank(5);
    chk("mrst_full_fd", fd_cnt - fd_base, 1);
    chk_frame("mrst_full", 4'd3, 4'd7, 4'd5, 4'd6, 4'h0, 4'h0);
    chk("mrst_full_valid", Digit_Valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
